// File: rtl/rx_pkg.sv
// rx_pkg: shared types and default widths for the receive-side drain logic.
//   state_e     - unloader FSM states.
//   *_W_DEF     - default data / RAM address / word-counter widths.
//   CSUM_W      - running checksum width (accumulates at the data width).
package rx_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 8;
  localparam int COUNT_W_DEF = 9;
  localparam int CSUM_W      = DATA_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage : rx_pkg

// File: rtl/rx_fifo_unloader.sv
// rx_fifo_unloader: drains the rvclk side of the DCFIFO into the receive RAM.
// Each start_i pulse runs one transfer of EXPECT_WORDS words, written to
// consecutive RAM addresses from 0, while counting and summing committed words.
//
// Ports:
//   clk_i, reset_n_i        receive clock, async active-low reset
//   start_i                 one-cycle pulse arming a transfer (IDLE/DONE only)
//   rdempty_i, data_i       FIFO empty flag and q (q valid the cycle after rdreq_o)
//   rdreq_o                 FIFO read request (combinational)
//   wren_o, addr_o, data_o  RAM write port (registered)
//   word_count_o            words committed this transfer
//   checksum_o              sum mod 2^DATA_W of committed words
//   busy_o, done_o          transfer in progress / transfer complete (held)
module rx_fifo_unloader
  import rx_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int COUNT_W      = COUNT_W_DEF,
  parameter int EXPECT_WORDS = 256
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               start_i,
  input  logic               rdempty_i,
  input  logic [DATA_W-1:0]  data_i,
  output logic               rdreq_o,
  output logic               wren_o,
  output logic [ADDR_W-1:0]  addr_o,
  output logic [DATA_W-1:0]  data_o,
  output logic [COUNT_W-1:0] word_count_o,
  output logic [DATA_W-1:0]  checksum_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam logic [COUNT_W-1:0] EXPECT_C = COUNT_W'(EXPECT_WORDS);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] issued_q, issued_d;
  logic               rd_vld_q;
  logic [ADDR_W-1:0]  wptr_q;
  logic               wren_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic [COUNT_W-1:0] word_count_q;
  logic [DATA_W-1:0]  checksum_q;
  logic               busy_q;
  logic               done_q;
  logic               start_acc;

  // A start pulse only counts when no transfer is in flight.
  assign start_acc = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Issued-read counter, next value. The DRAIN exit looks at this so that
  // FLUSH is entered the cycle right after the last read request.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    issued_d = issued_q;
    if (start_acc) begin
      issued_d = '0;
    end else if (rdreq_o) begin
      issued_d = issued_q + COUNT_W'(1);
    end
  end

  // FSM: state register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i)               state_d = ST_DRAIN;
      ST_DRAIN: if (issued_d == EXPECT_C)  state_d = ST_FLUSH;
      // Once no read is in flight, the final word is on the RAM port this
      // cycle, so the transfer is complete from the next cycle on.
      ST_FLUSH: if (!rd_vld_q)             state_d = ST_DONE;
      ST_DONE:  if (start_i)               state_d = ST_DRAIN;
      default:                             state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs. The read request never fires on an empty FIFO and stops
  // once the whole transfer has been requested.
  always_comb begin
    rdreq_o = (state_q == ST_DRAIN) && !rdempty_i && (issued_q < EXPECT_C);
  end

  // Datapath: read pipeline, RAM write port, count and checksum.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register here samples the pre-edge values of the others.
      issued_q     <= '0;
      rd_vld_q     <= 1'b0;
      wptr_q       <= '0;
      wren_q       <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      word_count_q <= '0;
      checksum_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      issued_q <= issued_d;
      rd_vld_q <= rdreq_o;
      wren_q   <= rd_vld_q;
      busy_q   <= (state_d == ST_DRAIN) || (state_d == ST_FLUSH);
      done_q   <= (state_d == ST_DONE);
      if (start_acc) begin
        wptr_q       <= '0;
        word_count_q <= '0;
        checksum_q   <= '0;
      end else if (rd_vld_q) begin
        // FIFO q is valid now: commit it to the RAM port and the totals.
        data_q       <= data_i;
        addr_q       <= wptr_q;
        wptr_q       <= wptr_q + ADDR_W'(1);
        word_count_q <= word_count_q + COUNT_W'(1);
        checksum_q   <= checksum_q + data_i;
      end
    end
  end

  assign wren_o       = wren_q;
  assign addr_o       = addr_q;
  assign data_o       = data_q;
  assign word_count_o = word_count_q;
  assign checksum_o   = checksum_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule : rx_fifo_unloader

// File: tb/tb_rx_fifo_unloader.sv
// tb_rx_fifo_unloader: randomized self-checking bench for rx_fifo_unloader.
// A queue models the FIFO (q valid the cycle after a read request); each
// scenario checks the logged RAM writes against the words it loaded.
module tb_rx_fifo_unloader;
  import rx_pkg::*;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int CW = 9;
  localparam int EW = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, start, rdempty, rdreq, wren, busy, done;
  logic [DW-1:0] data_in, data_out, csum;
  logic [AW-1:0] addr;
  logic [CW-1:0] wc;

  logic start_b, rdempty_b, rdreq_b, wren_b, busy_b, done_b;
  logic [DW-1:0] data_in_b, data_out_b, csum_b;
  logic [AW-1:0] addr_b;
  logic [CW-1:0] wc_b;

  rx_fifo_unloader #(.DATA_W(DW), .ADDR_W(AW), .COUNT_W(CW), .EXPECT_WORDS(EW)) u_dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .rdempty_i(rdempty),
    .data_i(data_in), .rdreq_o(rdreq), .wren_o(wren), .addr_o(addr),
    .data_o(data_out), .word_count_o(wc), .checksum_o(csum),
    .busy_o(busy), .done_o(done)
  );

  rx_fifo_unloader #(.DATA_W(DW), .ADDR_W(AW), .COUNT_W(CW), .EXPECT_WORDS(1)) u_dut_one (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start_b), .rdempty_i(rdempty_b),
    .data_i(data_in_b), .rdreq_o(rdreq_b), .wren_o(wren_b), .addr_o(addr_b),
    .data_o(data_out_b), .word_count_o(wc_b), .checksum_o(csum_b),
    .busy_o(busy_b), .done_o(done_b)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // FIFO model and pending read data
  logic [DW-1:0] fifo_q[$];
  logic          pend_vld = 1'b0;
  logic [DW-1:0] pend;
  int            gap_mode = 0;

  // Observation logs
  int              rdreq_cyc[$];
  int              wr_cyc[$];
  logic [AW-1:0]   wr_addr[$];
  logic [DW-1:0]   wr_data[$];
  logic [CW-1:0]   wr_cnt[$];
  logic [CSUM_W-1:0] wr_sum[$];
  int   done_rise, busy_rise, empty_viol, start_cyc;
  logic done_prev;

  // Expected words of the current transfer
  logic [DW-1:0] exp_q[$];

  task automatic clear_logs();
    rdreq_cyc.delete(); wr_cyc.delete(); wr_addr.delete();
    wr_data.delete(); wr_cnt.delete(); wr_sum.delete();
    done_rise = -1; busy_rise = -1; empty_viol = 0; done_prev = done;
  endtask

  // Advance one clock period: sample registered outputs at the falling edge,
  // present FIFO q / rdempty / start, then observe the read request.
  task automatic cycle(input bit st);
    @(negedge clk);
    cyc++;
    if (wren === 1'b1) begin
      wr_cyc.push_back(cyc); wr_addr.push_back(addr); wr_data.push_back(data_out);
      wr_cnt.push_back(wc); wr_sum.push_back(csum);
    end
    if (done === 1'b1 && done_prev !== 1'b1 && done_rise < 0) done_rise = cyc;
    done_prev = done;
    if (busy === 1'b1 && busy_rise < 0) busy_rise = cyc;
    data_in  = pend_vld ? pend : $urandom();
    pend_vld = 1'b0;
    case (gap_mode)
      1:       rdempty = (fifo_q.size() == 0) || ((cyc % 2) == 1);
      2:       rdempty = (fifo_q.size() == 0) || ($urandom_range(0, 3) == 0);
      default: rdempty = (fifo_q.size() == 0);
    endcase
    start = st;
    if (st) start_cyc = cyc;
    #1;
    if (rdreq === 1'b1) begin
      rdreq_cyc.push_back(cyc);
      if (rdempty) begin
        empty_viol++;
      end else begin
        pend     = fifo_q.pop_front();
        pend_vld = 1'b1;
      end
    end
  endtask

  task automatic run_to_done(input string name);
    int n = 0;
    while (done_rise < 0 && n < 3000) begin
      cycle(1'b0);
      n++;
    end
    total++;
    if (done_rise < 0) begin
      bad++;
      $display("FAIL %s_timeout done_o never rose within %0d cycles", name, n);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; rdempty = 1'b0; data_in = '0;
    start_b = 1'b0; rdempty_b = 1'b1; data_in_b = '0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({wren, busy, done, rdreq} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl got=%b want=0000", {wren, busy, done, rdreq});
    end
    total++;
    if (addr !== '0 || data_out !== '0) begin
      bad++; $display("FAIL reset_port addr=%h data=%h want 0/0", addr, data_out);
    end
    total++;
    if (wc !== '0 || csum !== '0) begin
      bad++; $display("FAIL reset_totals cnt=%0d sum=%h want 0/0", wc, csum);
    end
    total++;
    if ({wren_b, busy_b, done_b, rdreq_b, wc_b, csum_b} !== '0) begin
      bad++; $display("FAIL reset_one some output of the 1-word instance is nonzero");
    end
    @(negedge clk);
    reset_n = 1'b1;
    clear_logs();
    repeat (3) cycle(1'b0);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || rdreq_cyc.size() != 0) begin
      bad++; $display("FAIL idle_no_start busy=%b done=%b rdreqs=%0d want 0/0/0", busy, done, rdreq_cyc.size());
    end
  endtask

  // Compares the write log against exp_q (first EW words) and the timing rules.
  // Each scenario below repeats the word loop inline with its own name.
  task automatic test_full_transfer();
    logic [DW-1:0] run_sum = '0;
    int last;
    gap_mode = 0; exp_q.delete();
    for (int i = 0; i < EW; i++) begin fifo_q.push_back(DW'(i)); exp_q.push_back(DW'(i)); end
    clear_logs();
    cycle(1'b1);
    run_to_done("full");
    total++;
    if (busy_rise != start_cyc + 1 || rdreq_cyc.size() == 0 || rdreq_cyc[0] != start_cyc + 1) begin
      bad++; $display("FAIL full_start_timing busy_cyc=%0d first_rdreq=%0d want %0d", busy_rise,
                      (rdreq_cyc.size() > 0) ? rdreq_cyc[0] : -1, start_cyc + 1);
    end
    total++;
    if (wr_cyc.size() != EW || rdreq_cyc.size() != EW) begin
      bad++; $display("FAIL full_count writes=%0d rdreqs=%0d want %0d", wr_cyc.size(), rdreq_cyc.size(), EW);
    end
    for (int k = 0; k < wr_cyc.size() && k < EW; k++) begin
      run_sum += exp_q[k];
      total++;
      if (wr_addr[k] !== AW'(k) || wr_data[k] !== exp_q[k] || wr_cnt[k] !== CW'(k + 1) || wr_sum[k] !== run_sum) begin
        bad++; $display("FAIL full_word%0d got a=%h d=%h n=%0d s=%h want a=%h d=%h n=%0d s=%h", k,
                        wr_addr[k], wr_data[k], wr_cnt[k], wr_sum[k], AW'(k), exp_q[k], k + 1, run_sum);
      end
      total++;
      if (k < rdreq_cyc.size() && wr_cyc[k] != rdreq_cyc[k] + 2) begin
        bad++; $display("FAIL full_latency%0d write_cyc=%0d want %0d", k, wr_cyc[k], rdreq_cyc[k] + 2);
      end
    end
    last = (rdreq_cyc.size() > 0) ? rdreq_cyc[rdreq_cyc.size() - 1] : -100;
    total++;
    if (done_rise != last + 3 || busy !== 1'b0) begin
      bad++; $display("FAIL full_done_timing done_cyc=%0d busy=%b want %0d/0", done_rise, busy, last + 3);
    end
    total++;
    if (wc !== CW'(EW) || csum !== 32'h0000_7F80 || addr !== 8'hFF) begin
      bad++; $display("FAIL full_final cnt=%0d sum=%h addr=%h want 256/00007f80/ff", wc, csum, addr);
    end
  endtask

  task automatic test_gaps();
    logic [DW-1:0] run_sum = '0;
    gap_mode = 1; exp_q.delete();
    for (int i = 0; i < EW; i++) begin fifo_q.push_back(DW'(i)); exp_q.push_back(DW'(i)); end
    clear_logs();
    cycle(1'b1);
    run_to_done("gaps");
    total++;
    if (empty_viol != 0) begin
      bad++; $display("FAIL gaps_rdreq_on_empty count=%0d want 0", empty_viol);
    end
    total++;
    if (wr_cyc.size() != EW) begin
      bad++; $display("FAIL gaps_count writes=%0d want %0d", wr_cyc.size(), EW);
    end
    for (int k = 0; k < wr_cyc.size() && k < EW; k++) begin
      run_sum += exp_q[k];
      total++;
      if (wr_addr[k] !== AW'(k) || wr_data[k] !== exp_q[k] || wr_cnt[k] !== CW'(k + 1)) begin
        bad++; $display("FAIL gaps_word%0d got a=%h d=%h n=%0d want a=%h d=%h n=%0d", k,
                        wr_addr[k], wr_data[k], wr_cnt[k], AW'(k), exp_q[k], k + 1);
      end
    end
    total++;
    if (csum !== run_sum || csum !== 32'h0000_7F80 || wc !== CW'(EW)) begin
      bad++; $display("FAIL gaps_final sum=%h cnt=%0d want 00007f80/256", csum, wc);
    end
    gap_mode = 0;
  endtask

  task automatic test_overflow_random();
    logic [DW-1:0] run_sum = '0;
    logic [DW-1:0] w;
    int nreq;
    gap_mode = 2; exp_q.delete(); fifo_q.delete();
    for (int i = 0; i < 300; i++) begin
      w = $urandom();
      fifo_q.push_back(w);
      if (i < EW) exp_q.push_back(w);
    end
    clear_logs();
    cycle(1'b1);
    run_to_done("ovf");
    repeat (10) cycle(1'b0);
    nreq = rdreq_cyc.size();
    total++;
    if (nreq != EW || fifo_q.size() != 44 || empty_viol != 0) begin
      bad++; $display("FAIL ovf_reads rdreqs=%0d left=%0d empty_viol=%0d want 256/44/0", nreq, fifo_q.size(), empty_viol);
    end
    total++;
    if (wr_cyc.size() != EW) begin
      bad++; $display("FAIL ovf_count writes=%0d want %0d", wr_cyc.size(), EW);
    end
    for (int k = 0; k < wr_cyc.size() && k < EW; k++) begin
      run_sum += exp_q[k];
      total++;
      if (wr_addr[k] !== AW'(k) || wr_data[k] !== exp_q[k] || wr_sum[k] !== run_sum) begin
        bad++; $display("FAIL ovf_word%0d got a=%h d=%h s=%h want a=%h d=%h s=%h", k,
                        wr_addr[k], wr_data[k], wr_sum[k], AW'(k), exp_q[k], run_sum);
      end
    end
    total++;
    if (csum !== run_sum || wc !== CW'(EW) || done !== 1'b1) begin
      bad++; $display("FAIL ovf_final sum=%h cnt=%0d done=%b want %h/256/1", csum, wc, done, run_sum);
    end
    gap_mode = 0; fifo_q.delete();
  endtask

  task automatic test_restart();
    logic [DW-1:0] run_sum = '0;
    int n = 0;
    gap_mode = 0; exp_q.delete();
    for (int i = 0; i < EW; i++) begin exp_q.push_back($urandom()); fifo_q.push_back(exp_q[i]); end
    clear_logs();
    cycle(1'b1);
    // Extra start pulse in the middle of DRAIN must be ignored.
    while (done_rise < 0 && n < 3000) begin
      cycle(n == 50);
      n++;
    end
    total++;
    if (done_rise < 0 || wr_cyc.size() != EW) begin
      bad++; $display("FAIL restart_first writes=%0d done_cyc=%0d want %0d writes", wr_cyc.size(), done_rise, EW);
    end
    for (int k = 0; k < wr_cyc.size() && k < EW; k++) begin
      run_sum += exp_q[k];
      total++;
      if (wr_addr[k] !== AW'(k) || wr_data[k] !== exp_q[k] || wr_cnt[k] !== CW'(k + 1) || wr_sum[k] !== run_sum) begin
        bad++; $display("FAIL restart_word%0d got a=%h n=%0d s=%h want a=%h n=%0d s=%h", k,
                        wr_addr[k], wr_cnt[k], wr_sum[k], AW'(k), k + 1, run_sum);
      end
    end
    // Second transfer from DONE.
    exp_q.delete(); run_sum = '0;
    for (int i = 0; i < EW; i++) begin exp_q.push_back($urandom()); fifo_q.push_back(exp_q[i]); end
    clear_logs();
    cycle(1'b1);
    cycle(1'b0);
    total++;
    if (wc !== '0 || csum !== '0 || done !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL restart_clear cnt=%0d sum=%h done=%b busy=%b want 0/0/0/1", wc, csum, done, busy);
    end
    run_to_done("restart2");
    for (int k = 0; k < EW; k++) run_sum += exp_q[k];
    total++;
    if (wr_cyc.size() != EW || wr_addr[0] !== '0 || wr_data[0] !== exp_q[0]) begin
      bad++; $display("FAIL restart_second writes=%0d first_addr=%h first_data=%h want %0d/00/%h",
                      wr_cyc.size(), (wr_cyc.size() > 0) ? wr_addr[0] : 8'hxx,
                      (wr_cyc.size() > 0) ? wr_data[0] : 32'hx, EW, exp_q[0]);
    end
    total++;
    if (csum !== run_sum || wc !== CW'(EW)) begin
      bad++; $display("FAIL restart_second_totals sum=%h cnt=%0d want %h/256", csum, wc, run_sum);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    gap_mode = 0; fifo_q.delete();
    for (int i = 0; i < EW; i++) fifo_q.push_back($urandom());
    clear_logs();
    cycle(1'b1);
    while (wr_cyc.size() < 100 && n < 3000) begin
      cycle(1'b0);
      n++;
    end
    total++;
    if (wr_cyc.size() != 100) begin
      bad++; $display("FAIL rstmid_reach writes=%0d want 100", wr_cyc.size());
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if ({wren, busy, done, rdreq} !== 4'b0000 || addr !== '0 || data_out !== '0 || wc !== '0 || csum !== '0) begin
      bad++; $display("FAIL rstmid_clear wren=%b busy=%b done=%b rdreq=%b addr=%h data=%h cnt=%0d sum=%h want all 0",
                      wren, busy, done, rdreq, addr, data_out, wc, csum);
    end
    @(negedge clk);
    reset_n  = 1'b1;
    pend_vld = 1'b0;
    clear_logs();
    repeat (20) cycle(1'b0);
    total++;
    if (wr_cyc.size() != 0 || rdreq_cyc.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL rstmid_idle writes=%0d rdreqs=%0d busy=%b want 0/0/0", wr_cyc.size(), rdreq_cyc.size(), busy);
    end
    fifo_q.delete();
  endtask

  task automatic test_single_word();
    int nw = 0, nr = 0;
    logic [AW-1:0] a = 'x;
    logic [DW-1:0] d = 'x;
    @(negedge clk);
    rdempty_b = 1'b0; data_in_b = 32'hFFFF_FFFF; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (wren_b === 1'b1) begin nw++; a = addr_b; d = data_out_b; end
      #1;
      if (rdreq_b === 1'b1) nr++;
      @(negedge clk);
    end
    total++;
    if (nw != 1 || nr != 1 || a !== '0 || d !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL one_write writes=%0d rdreqs=%0d addr=%h data=%h want 1/1/00/ffffffff", nw, nr, a, d);
    end
    total++;
    if (csum_b !== 32'hFFFF_FFFF || wc_b !== CW'(1) || done_b !== 1'b1 || busy_b !== 1'b0) begin
      bad++; $display("FAIL one_final sum=%h cnt=%0d done=%b busy=%b want ffffffff/1/1/0", csum_b, wc_b, done_b, busy_b);
    end
    rdempty_b = 1'b1;
  endtask

  initial begin
    test_reset();
    test_full_transfer();
    test_gaps();
    test_overflow_random();
    test_restart();
    test_reset_mid();
    test_single_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_rx_fifo_unloader
